// File: rtl/video_stream_pkg.sv
// Shared types for the video stream source: controller states and pattern codes.
package video_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [1:0] PAT_COUNT = 2'd0;
  localparam logic [1:0] PAT_XY    = 2'd1;
  localparam logic [1:0] PAT_SOLID = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

endpackage

// File: rtl/video_xy_counter.sv
// Raster position tracker: x/y coordinates plus a running pixel index.
// The "next" outputs describe the position that will be presented after this
// edge, which lets the parent register pixel data without a multiplier.
module video_xy_counter #(
  parameter int DIM_W = 12,
  parameter int P_W   = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic [DIM_W-1:0] i_width,
  input  logic [DIM_W-1:0] i_height,
  output logic [DIM_W-1:0] o_nextX,
  output logic [DIM_W-1:0] o_nextY,
  output logic [P_W-1:0]   o_nextP,
  output logic             o_isFirst,
  output logic             o_isLast
);

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
  localparam logic [P_W-1:0]   P_ONE   = P_W'(1);

  logic [DIM_W-1:0] r_x;
  logic [DIM_W-1:0] r_y;
  logic [P_W-1:0]   r_p;

  logic [DIM_W-1:0] w_nextX;
  logic [DIM_W-1:0] w_nextY;
  logic [P_W-1:0]   w_nextP;

  // Step along the raster: end of line wraps x, end of frame wraps everything.
  always_comb begin
    w_nextX = r_x;
    w_nextY = r_y;
    w_nextP = r_p;
    if (i_clear) begin
      w_nextX = '0;
      w_nextY = '0;
      w_nextP = '0;
    end else if (i_advance) begin
      if (r_x == i_width - DIM_ONE) begin
        w_nextX = '0;
        if (r_y == i_height - DIM_ONE) begin
          w_nextY = '0;
          w_nextP = '0;
        end else begin
          w_nextY = r_y + DIM_ONE;
          w_nextP = r_p + P_ONE;
        end
      end else begin
        w_nextX = r_x + DIM_ONE;
        w_nextP = r_p + P_ONE;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
      r_p <= '0;
    end else begin
      r_x <= w_nextX;
      r_y <= w_nextY;
      r_p <= w_nextP;
    end
  end

  assign o_nextX   = w_nextX;
  assign o_nextY   = w_nextY;
  assign o_nextP   = w_nextP;
  assign o_isFirst = (w_nextX == '0) && (w_nextY == '0);
  assign o_isLast  = (w_nextX == i_width - DIM_ONE) && (w_nextY == i_height - DIM_ONE);

endmodule

// File: rtl/video_stream_source.sv
// Avalon-ST video source: emits W x H frames with SOP/EOP framing, honours
// ready backpressure, inserts an idle gap between frames and generates a
// selectable test pattern. All stream outputs are registered.
module video_stream_source
  import video_stream_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int DIM_W      = 12,
  parameter int GAP_CYCLES = 4,
  parameter int FCNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic              io_stop,
  input  logic [DIM_W-1:0]  io_width,
  input  logic [DIM_W-1:0]  io_height,
  input  logic [FCNT_W-1:0] io_frames,
  input  logic [1:0]        io_pattern,
  input  logic [DATA_W-1:0] io_color,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_out_startofpacket,
  output logic              io_out_endofpacket,
  output logic [1:0]        io_out_empty,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic              io_busy,
  output logic [FCNT_W-1:0] io_frames_done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [FCNT_W-1:0] FRAME_ONE = FCNT_W'(1);

  state_t r_state;
  state_t w_nState;

  logic [DIM_W-1:0]  r_width;
  logic [DIM_W-1:0]  r_height;
  logic [FCNT_W-1:0] r_frames;
  logic [1:0]        r_pattern;
  logic [DATA_W-1:0] r_color;

  logic [GAP_W-1:0]  r_gapCnt;
  logic [FCNT_W-1:0] r_framesDone;
  logic              r_stopPending;

  logic              r_valid;
  logic              r_sop;
  logic              r_eop;
  logic [DATA_W-1:0] r_data;

  logic [DIM_W-1:0]  w_cfgWidth;
  logic [DIM_W-1:0]  w_cfgHeight;
  logic [1:0]        w_cfgPattern;
  logic [DATA_W-1:0] w_cfgColor;

  logic              w_cntClear;
  logic              w_cntAdvance;
  logic [DIM_W-1:0]  w_nextX;
  logic [DIM_W-1:0]  w_nextY;
  logic [DATA_W-1:0] w_nextP;
  logic              w_isFirst;
  logic              w_isLast;

  logic [2*DIM_W-1:0] w_xy;
  logic [DATA_W-1:0]  w_pix;

  logic              w_xfer;
  logic              w_lastFrame;
  logic              w_startAccept;
  logic [GAP_W-1:0]  w_nGapCnt;
  logic [FCNT_W-1:0] w_nFramesDone;
  logic              w_nStopPending;
  logic              w_nValid;
  logic              w_nSop;
  logic              w_nEop;
  logic [DATA_W-1:0] w_nData;

  // While idle the live inputs describe the frame about to start; once running
  // only the latched copies matter, so mid-run config changes are ignored.
  always_comb begin
    w_cfgWidth   = r_width;
    w_cfgHeight  = r_height;
    w_cfgPattern = r_pattern;
    w_cfgColor   = r_color;
    if (r_state == IDLE) begin
      w_cfgWidth   = io_width;
      w_cfgHeight  = io_height;
      w_cfgPattern = io_pattern;
      w_cfgColor   = io_color;
    end
  end

  video_xy_counter #(
    .DIM_W (DIM_W),
    .P_W   (DATA_W)
  ) u_xy (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_cntClear),
    .i_advance (w_cntAdvance),
    .i_width   (w_cfgWidth),
    .i_height  (w_cfgHeight),
    .o_nextX   (w_nextX),
    .o_nextY   (w_nextY),
    .o_nextP   (w_nextP),
    .o_isFirst (w_isFirst),
    .o_isLast  (w_isLast)
  );

  // Pattern generator evaluated at the position that will be presented next.
  always_comb begin
    w_xy  = {w_nextY, w_nextX};
    w_pix = '0;
    case (w_cfgPattern)
      PAT_COUNT: w_pix = w_nextP;
      PAT_XY:    w_pix = DATA_W'(w_xy);
      PAT_SOLID: w_pix = w_cfgColor;
      default:   w_pix = (w_nextX[3] ^ w_nextY[3]) ? ~w_cfgColor : w_cfgColor;
    endcase
  end

  assign w_xfer      = r_valid & io_out_ready;
  assign w_lastFrame = (r_frames != '0) && ((r_framesDone + FRAME_ONE) == r_frames);

  // Controller: next state, counter control and the next registered beat.
  always_comb begin
    w_nState       = r_state;
    w_cntClear     = 1'b0;
    w_cntAdvance   = 1'b0;
    w_startAccept  = 1'b0;
    w_nGapCnt      = r_gapCnt;
    w_nFramesDone  = r_framesDone;
    w_nStopPending = r_stopPending;
    w_nValid       = r_valid;
    w_nSop         = r_sop;
    w_nEop         = r_eop;
    w_nData        = r_data;
    case (r_state)
      IDLE: begin
        w_cntClear     = 1'b1;
        w_nStopPending = 1'b0;
        if (io_start && (io_width != '0) && (io_height != '0)) begin
          w_startAccept = 1'b1;
          w_nState      = ACTIVE;
          w_nFramesDone = '0;
          w_nValid      = 1'b1;
          w_nSop        = w_isFirst;
          w_nEop        = w_isLast;
          w_nData       = w_pix;
        end
      end
      ACTIVE: begin
        if (io_stop) begin
          w_nStopPending = 1'b1;
        end
        if (w_xfer) begin
          w_cntAdvance = 1'b1;
          if (r_eop) begin
            w_nFramesDone = r_framesDone + FRAME_ONE;
            if (r_stopPending || io_stop || w_lastFrame) begin
              w_nState       = IDLE;
              w_nStopPending = 1'b0;
              w_nValid       = 1'b0;
              w_nSop         = 1'b0;
              w_nEop         = 1'b0;
              w_nData        = '0;
            end else if (GAP_CYCLES == 0) begin
              w_nValid = 1'b1;
              w_nSop   = w_isFirst;
              w_nEop   = w_isLast;
              w_nData  = w_pix;
            end else begin
              w_nState  = GAP;
              w_nGapCnt = '0;
              w_nValid  = 1'b0;
              w_nSop    = 1'b0;
              w_nEop    = 1'b0;
              w_nData   = '0;
            end
          end else begin
            w_nValid = 1'b1;
            w_nSop   = w_isFirst;
            w_nEop   = w_isLast;
            w_nData  = w_pix;
          end
        end
      end
      GAP: begin
        if (io_stop) begin
          w_nState       = IDLE;
          w_nStopPending = 1'b0;
        end else if (r_gapCnt == GAP_LAST) begin
          w_nState = ACTIVE;
          w_nValid = 1'b1;
          w_nSop   = w_isFirst;
          w_nEop   = w_isLast;
          w_nData  = w_pix;
        end else begin
          w_nGapCnt = r_gapCnt + GAP_ONE;
        end
      end
      default: begin
        w_nState = IDLE;
        w_nValid = 1'b0;
        w_nSop   = 1'b0;
        w_nEop   = 1'b0;
        w_nData  = '0;
      end
    endcase
  end

  // State, gap/frame bookkeeping and the registered stream beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_gapCnt      <= '0;
      r_framesDone  <= '0;
      r_stopPending <= 1'b0;
      r_valid       <= 1'b0;
      r_sop         <= 1'b0;
      r_eop         <= 1'b0;
      r_data        <= '0;
    end else begin
      r_state       <= w_nState;
      r_gapCnt      <= w_nGapCnt;
      r_framesDone  <= w_nFramesDone;
      r_stopPending <= w_nStopPending;
      r_valid       <= w_nValid;
      r_sop         <= w_nSop;
      r_eop         <= w_nEop;
      r_data        <= w_nData;
    end
  end

  // Configuration snapshot taken when a start is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_width   <= '0;
      r_height  <= '0;
      r_frames  <= '0;
      r_pattern <= '0;
      r_color   <= '0;
    end else if (w_startAccept) begin
      r_width   <= io_width;
      r_height  <= io_height;
      r_frames  <= io_frames;
      r_pattern <= io_pattern;
      r_color   <= io_color;
    end
  end

  assign io_out_data          = r_data;
  assign io_out_startofpacket = r_sop;
  assign io_out_endofpacket   = r_eop;
  assign io_out_empty         = 2'b00;
  assign io_out_valid         = r_valid;
  assign io_busy              = (r_state != IDLE);
  assign io_frames_done       = r_framesDone;

endmodule

// File: tb/tb_video_stream_source.sv
// Self-checking bench for video_stream_source: table-driven frame runs,
// randomized runs against a raster model, and hand-written corner sequences.
module tb_video_stream_source;

  localparam int GAP = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_start;
  logic        io_stop;
  logic [11:0] io_width;
  logic [11:0] io_height;
  logic [15:0] io_frames;
  logic [1:0]  io_pattern;
  logic [23:0] io_color;
  logic [23:0] io_out_data;
  logic        io_out_startofpacket;
  logic        io_out_endofpacket;
  logic [1:0]  io_out_empty;
  logic        io_out_valid;
  logic        io_out_ready;
  logic        io_busy;
  logic [15:0] io_frames_done;

  int checks   = 0;
  int failures = 0;

  video_stream_source #(
    .DATA_W     (24),
    .DIM_W      (12),
    .GAP_CYCLES (GAP),
    .FCNT_W     (16)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .io_start             (io_start),
    .io_stop              (io_stop),
    .io_width             (io_width),
    .io_height            (io_height),
    .io_frames            (io_frames),
    .io_pattern           (io_pattern),
    .io_color             (io_color),
    .io_out_data          (io_out_data),
    .io_out_startofpacket (io_out_startofpacket),
    .io_out_endofpacket   (io_out_endofpacket),
    .io_out_empty         (io_out_empty),
    .io_out_valid         (io_out_valid),
    .io_out_ready         (io_out_ready),
    .io_busy              (io_busy),
    .io_frames_done       (io_frames_done)
  );

  // 100 MHz clock.
  always #5 clock = ~clock;

  typedef struct {
    int          w;
    int          h;
    int          frames;
    logic [1:0]  pat;
    logic [23:0] color;
    int          readyMode;
    int          expDone;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Expected {sop, eop, data} of pixel p of a w x h frame.
  function automatic logic [25:0] modelBeat(input int w, input int h, input int p,
                                            input logic [1:0] pat, input logic [23:0] color);
    int          x;
    int          y;
    logic [31:0] xv;
    logic [31:0] yv;
    logic [31:0] pv;
    logic [23:0] d;
    x  = p % w;
    y  = p / w;
    xv = x;
    yv = y;
    pv = p;
    case (pat)
      2'd0:    d = pv[23:0];
      2'd1:    d = {yv[11:0], xv[11:0]};
      2'd2:    d = color;
      default: d = (((x / 8) % 2) != ((y / 8) % 2)) ? ~color : color;
    endcase
    return {(p == 0), (p == w * h - 1), d};
  endfunction

  task automatic applyStimulus(input int w, input int h, input int frames,
                               input logic [1:0] pat, input logic [23:0] color);
    @(negedge clock);
    io_width   = 12'(w);
    io_height  = 12'(h);
    io_frames  = 16'(frames);
    io_pattern = pat;
    io_color   = color;
    io_start   = 1'b1;
    @(negedge clock);
    io_start   = 1'b0;
    io_width   = 12'($urandom);
    io_height  = 12'($urandom);
    io_frames  = 16'($urandom);
    io_pattern = 2'($urandom);
    io_color   = 24'($urandom);
  endtask

  task automatic runCase(input string tag, input int w, input int h, input int frames,
                         input logic [1:0] pat, input logic [23:0] color,
                         input int readyMode, input int expDone);
    logic [25:0] expQ[$];
    logic [25:0] expBeat;
    logic [26:0] beat;
    logic [26:0] prevBeat;
    logic        stalled;
    logic        inGap;
    int          gapLen;
    int          cyc;
    int          xfers;
    stalled  = 1'b0;
    inGap    = 1'b0;
    gapLen   = 0;
    cyc      = 0;
    xfers    = 0;
    prevBeat = '0;
    for (int f = 0; f < frames; f++)
      for (int p = 0; p < w * h; p++)
        expQ.push_back(modelBeat(w, h, p, pat, color));
    if (readyMode == 0) io_out_ready = 1'b1;
    applyStimulus(w, h, frames, pat, color);
    checkOutput({tag, " latency"}, io_out_valid, 1);
    while ((expQ.size() != 0 || io_busy) && cyc < 1000) begin
      case (readyMode)
        0:       io_out_ready = 1'b1;
        1:       io_out_ready = ((cyc % 3) == 0);
        default: io_out_ready = 1'($urandom_range(0, 1));
      endcase
      if (readyMode == 2) begin
        io_start  = ($urandom_range(0, 7) == 0);
        io_width  = 12'($urandom_range(0, 7));
        io_height = 12'($urandom_range(0, 7));
      end
      beat = {io_out_valid, io_out_startofpacket, io_out_endofpacket, io_out_data};
      if (stalled) checkOutput({tag, " hold"}, beat, prevBeat);
      if (io_out_valid) begin
        if (inGap) begin
          checkOutput({tag, " gap"}, gapLen, GAP);
          inGap = 1'b0;
        end
        if (io_out_ready) begin
          if (expQ.size() != 0) begin
            expBeat = expQ.pop_front();
            checkOutput({tag, " beat"}, beat[25:0], expBeat);
          end
          xfers++;
          if (io_out_endofpacket) begin
            inGap  = 1'b1;
            gapLen = 0;
          end
        end
      end else if (inGap) begin
        gapLen++;
      end
      stalled  = io_out_valid && !io_out_ready;
      prevBeat = beat;
      @(negedge clock);
      cyc++;
    end
    io_start = 1'b0;
    checkOutput({tag, " finished"}, (expQ.size() == 0) && !io_busy, 1);
    checkOutput({tag, " transfers"}, xfers, frames * w * h);
    checkOutput({tag, " frames_done"}, io_frames_done, expDone);
    checkOutput({tag, " idle_valid"}, io_out_valid, 0);
  endtask

  task automatic runStop(input string tag, input int w, input int h,
                         input int stopCycle, input int expBeats);
    int n;
    int idx;
    n = 0;
    io_out_ready = 1'b1;
    applyStimulus(w, h, 0, 2'd0, 24'h0);
    for (int c = 0; c < 40; c++) begin
      io_stop = (c == stopCycle);
      if (io_out_valid) begin
        idx = n % (w * h);
        checkOutput({tag, " beat"}, {io_out_startofpacket, io_out_endofpacket, io_out_data},
                    {(idx == 0), (idx == w * h - 1), 24'(idx)});
        n++;
      end
      @(negedge clock);
    end
    io_stop = 1'b0;
    checkOutput({tag, " beats"}, n, expBeats);
    checkOutput({tag, " frames_done"}, io_frames_done, expBeats / (w * h));
    checkOutput({tag, " busy"}, io_busy, 0);
  endtask

  // Global watchdog so a hung run still ends with a report.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t        vecs[$];
  logic [23:0] xyExp[4];

  // Main test sequence.
  initial begin
    reset        = 1'b1;
    io_start     = 1'b0;
    io_stop      = 1'b0;
    io_width     = '0;
    io_height    = '0;
    io_frames    = '0;
    io_pattern   = '0;
    io_color     = '0;
    io_out_ready = 1'b0;

    vecs.push_back('{w: 4,  h: 2, frames: 1, pat: 2'd0, color: 24'h000000, readyMode: 0, expDone: 1});
    vecs.push_back('{w: 4,  h: 2, frames: 1, pat: 2'd0, color: 24'h000000, readyMode: 1, expDone: 1});
    vecs.push_back('{w: 2,  h: 2, frames: 2, pat: 2'd1, color: 24'h000000, readyMode: 0, expDone: 2});
    vecs.push_back('{w: 1,  h: 1, frames: 1, pat: 2'd2, color: 24'hABCDEF, readyMode: 0, expDone: 1});
    vecs.push_back('{w: 5,  h: 3, frames: 2, pat: 2'd3, color: 24'h123456, readyMode: 1, expDone: 2});
    vecs.push_back('{w: 16, h: 2, frames: 1, pat: 2'd3, color: 24'h0F0F0F, readyMode: 0, expDone: 1});
    vecs.push_back('{w: 3,  h: 1, frames: 3, pat: 2'd0, color: 24'h000000, readyMode: 1, expDone: 3});

    xyExp[0] = 24'h000000;
    xyExp[1] = 24'h000001;
    xyExp[2] = 24'h001000;
    xyExp[3] = 24'h001001;

    @(negedge clock);
    @(negedge clock);
    checkOutput("reset outputs",
                {io_out_valid, io_out_startofpacket, io_out_endofpacket, io_out_data, io_out_empty, io_busy},
                0);
    checkOutput("reset frames_done", io_frames_done, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      runCase($sformatf("vec%0d", i), vecs[i].w, vecs[i].h, vecs[i].frames,
              vecs[i].pat, vecs[i].color, vecs[i].readyMode, vecs[i].expDone);

    io_out_ready = 1'b1;
    applyStimulus(2, 2, 1, 2'd1, 24'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("xy data %0d", i), io_out_data, xyExp[i]);
      @(negedge clock);
    end
    checkOutput("xy end valid", io_out_valid, 0);

    runStop("stop mid", 3, 3, 3, 9);
    runStop("stop at eop", 2, 1, 1, 2);
    runStop("stop in gap", 1, 1, 2, 1);

    io_stop = 1'b1;
    @(negedge clock);
    io_stop = 1'b0;
    runCase("idle stop", 1, 1, 2, 2'd2, 24'h555555, 0, 2);

    io_out_ready = 1'b1;
    applyStimulus(4, 4, 1, 2'd0, 24'h0);
    for (int c = 0; c < 5; c++) @(negedge clock);
    checkOutput("rst pre data", io_out_data, 5);
    reset = 1'b1;
    #1;
    checkOutput("rst async outputs",
                {io_out_valid, io_out_startofpacket, io_out_endofpacket, io_out_data, io_busy}, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst released idle", {io_out_valid, io_busy}, 0);
    runCase("post reset", 4, 4, 1, 2'd0, 24'h0, 0, 1);

    applyStimulus(0, 3, 1, 2'd2, 24'h111111);
    for (int c = 0; c < 4; c++) begin
      checkOutput("zero width idle", {io_out_valid, io_busy}, 0);
      @(negedge clock);
    end
    applyStimulus(3, 0, 1, 2'd2, 24'h111111);
    checkOutput("zero height idle", {io_out_valid, io_busy}, 0);

    for (int i = 0; i < 6; i++) begin
      int          rw;
      int          rh;
      int          rf;
      logic [1:0]  rp;
      logic [23:0] rc;
      rw = $urandom_range(1, 5);
      rh = $urandom_range(1, 4);
      rf = $urandom_range(1, 3);
      rp = 2'($urandom);
      rc = 24'($urandom);
      runCase($sformatf("rand%0d", i), rw, rh, rf, rp, rc, 2, rf);
    end

    checkOutput("empty", io_out_empty, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
